// File: rtl/traffic_phase_arbiter_if.sv
// rtl/traffic_phase_arbiter_if.sv - request and lamp buses of the four-approach phase arbiter
`timescale 1ns/1ps

interface traffic_phase_arbiter_if #(
    parameter int CNT_W = 5
);
    logic [3:0]       req;
    logic [1:0]       north_both;
    logic [1:0]       south_both;
    logic [1:0]       east_both;
    logic [1:0]       west_both;
    logic [1:0]       phase_dir;
    logic [CNT_W-1:0] count;

    modport master (
        output req,
        input  north_both, south_both, east_both, west_both, phase_dir, count
    );

    modport slave (
        input  req,
        output north_both, south_both, east_both, west_both, phase_dir, count
    );
endinterface

// File: rtl/traffic_phase_arbiter.sv
// rtl/traffic_phase_arbiter.sv - round-robin green-phase scheduler for a four-approach intersection
// Lamp buses are registered from the next state, so a light can only change on a clock edge or reset.
`timescale 1ns/1ps

module traffic_phase_arbiter #(
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 2,
    parameter int CNT_W     = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    traffic_phase_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_GREEN, S_YELLOW, S_ALL_RED} state_t;

    localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALL_RED - 1);

    state_t           state_q, state_d;
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0][1:0]  light_q, light_d;
    logic [3:0]       others;

    // First requesting approach at or after p, wrapping modulo 4.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] w;
        logic [1:0] idx;
        w = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) begin
                w = idx;
            end
        end
        return w;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            dir_q   <= 2'd0;
            ptr_q   <= 2'd0;
            count_q <= '0;
            light_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            light_q <= light_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        ptr_d   = ptr_q;
        others  = bus.req & ~(4'b0001 << dir_q);
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    state_d = S_GREEN;
                    dir_d   = pick(bus.req, ptr_q);
                end
            end
            S_GREEN: begin
                if ((|others) && (((count_q >= GMIN_M1) && !bus.req[dir_q]) || (count_q == GMAX_M1))) begin
                    state_d = S_YELLOW;
                end
            end
            S_YELLOW: begin
                if (count_q == YEL_M1) begin
                    state_d = S_ALL_RED;
                end
            end
            S_ALL_RED: begin
                if (count_q == AR_M1) begin
                    // The approach just served drops to lowest priority.
                    ptr_d = dir_q + 2'd1;
                    if (|bus.req) begin
                        state_d = S_GREEN;
                        dir_d   = pick(bus.req, dir_q + 2'd1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = '0;
        if (state_d == state_q) begin
            case (state_q)
                S_GREEN:              count_d = (count_q == GMAX_M1) ? count_q : count_q + 1'b1;
                S_YELLOW, S_ALL_RED:  count_d = count_q + 1'b1;
                default:              count_d = '0;
            endcase
        end
        light_d = '0;
        case (state_d)
            S_GREEN:  light_d[dir_d] = 2'b10;
            S_YELLOW: light_d[dir_d] = 2'b01;
            default:  light_d = '0;
        endcase
    end

    assign bus.north_both = light_q[0];
    assign bus.south_both = light_q[1];
    assign bus.east_both  = light_q[2];
    assign bus.west_both  = light_q[3];
    assign bus.phase_dir  = dir_q;
    assign bus.count      = count_q;
endmodule

// File: doc/traffic_phase_arbiter.md
# traffic_phase_arbiter

Round-robin green-phase scheduler for a four-approach intersection. It takes level-sensitive vehicle-presence requests from the North, South, East and West approaches and grants green to one approach at a time. Each grant is bounded by minimum and maximum green timers and followed by fixed yellow and all-red clearance intervals. It drives the per-approach 2-bit light buses (`north_both` .. `west_both`) consumed by the lamp drivers, replacing the fixed-cycle sequencing with demand-driven arbitration.

## Interface
- `GREEN_MIN`, 8: minimum green length in clock cycles.
- `GREEN_MAX`, 20: maximum green length in cycles while other approaches are waiting.
- `YELLOW`, 3: yellow interval in cycles.
- `ALL_RED`, 2: all-red clearance interval in cycles.
- `CNT_W`, 5: phase counter width.
  - Legal when 1 ≤ `GREEN_MIN` ≤ `GREEN_MAX` ≤ 2^`CNT_W`, and `YELLOW`, `ALL_RED` ≤ 2^`CNT_W`.
  - `YELLOW` ≥ 1 and `ALL_RED` ≥ 1.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req`  in  4  vehicle presence, level-sensitive: bit0 N, bit1 S, bit2 E, bit3 W.
- `north_both`  out  2  North light: 2'b00 red, 2'b01 yellow, 2'b10 green (2'b11 never driven).
- `south_both`  out  2  South light, same encoding.
- `east_both`  out  2  East light, same encoding.
- `west_both`  out  2  West light, same encoding.
- `phase_dir`  out  2  index of the approach currently or last granted (0 N, 1 S, 2 E, 3 W).
- `count`  out  `CNT_W`  cycles elapsed in the current state.

## Operation
- **States:** IDLE, GREEN, YELLOW, ALL_RED. All outputs are registered.
- **Reset (`rst`=0):** asynchronous, takes effect immediately.
  - State IDLE, all lights 2'b00, `count`=0, `phase_dir`=0.
  - Round-robin pointer `ptr`=0, so N has first priority.
- **Arbitration:** the winner is the first set bit of `req`, searching `ptr`, `ptr`+1, ... modulo 4.
- **IDLE:** all lights red, `count` held at 0.
  - If `req`≠0: go to GREEN for the winner and set `phase_dir` to the winner.
- **GREEN:** only the granted light is 2'b10. `count` increments and saturates at `GREEN_MAX`-1.
  - `others` = `req` with the granted bit cleared.
  - Exit to YELLOW when `others`≠0 and either:
    - (`count` ≥ `GREEN_MIN`-1 and own `req` bit is 0), or
    - `count` == `GREEN_MAX`-1.
  - If `others`=0: rest in green indefinitely. Own request is irrelevant in this case.
- **YELLOW:** granted light is 2'b01, others red.
  - Advance to ALL_RED when `count` == `YELLOW`-1.
- **ALL_RED:** all lights red.
  - At `count` == `ALL_RED`-1: `ptr` ← `phase_dir`+1 (wraps 3→0), then arbitrate using the new `ptr`.
  - If `req`≠0: go to GREEN for the winner. Otherwise go to IDLE.
- **`count`:** cleared to 0 on every state entry.
- **Requests:** never latched. A request that drops before it is sampled at an arbitration point is lost.
- **Safety invariant:** at most one light is non-red in any cycle. No direct green→red transition; no green→green transition without YELLOW and ALL_RED between.

## Timing
- **IDLE to GREEN:** `req` sampled at edge t produces green on that approach's bus after edge t; `phase_dir` updates on the same edge. Latency is 1 cycle.
- **Green length:**
  - Others waiting and own request low: exactly `GREEN_MIN` cycles.
  - Others waiting and own request held: exactly `GREEN_MAX` cycles.
- **Fixed intervals:** yellow is exactly `YELLOW` cycles; all-red is exactly `ALL_RED` cycles.
- **Back-to-back grant:** the next green starts on the cycle after the last all-red cycle.
- **Late request:** a request arriving during YELLOW or ALL_RED is honoured at the ALL_RED exit if still asserted.
- **Simultaneous requests:** resolved purely by the rotating priority starting at `ptr`.
- **Own approach at the pointer:** the just-served approach has the lowest priority at ALL_RED exit, so it regains green only if no other approach is requesting.
- **Reset mid-phase:** lights go red asynchronously regardless of state. After release, operation restarts from IDLE with `ptr`=0.

## Test plan
- **Reset and idle:** hold `rst`=0, then release with `req`=0 for 100 cycles → all buses 2'b00, `count`=0, `phase_dir`=0 throughout.
- **Rest in green:** `req`=4'b0100 from IDLE → `east_both`=2'b10 one cycle later. Holding `req` → green persists, `count` saturates at 19, no yellow.
- **Minimum green:** N granted, then `req`=4'b0010 (N dropped, S waiting) → N green 8 cycles total, N yellow 3, all red 2, then `south_both`=2'b10.
- **Maximum green:** `req`=4'b0101 held → N green 20, yellow 3, red 2, E green 20, yellow 3, red 2, N again. W and S never granted.
- **Round-robin order:** `req`=4'b1111 held → grant order N, S, E, W, N. Each green is 20 cycles; `phase_dir` steps 0,1,2,3,0.
- **Reset mid-operation:** assert `rst`=0 during E yellow (`count`=1) → all buses 2'b00 before the next edge. After release with `req`=4'b1100, E is granted (`ptr` reset to 0, first set bit from N is E).
